// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared state encoding and default frame width for spi_rx
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int C_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RECV = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// sync2 : multi-flop input synchronizer (default 2 flops) with reset value
// Rev 1.0
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_chain <= RST_VAL;
                else        r_chain <= d;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_chain <= {STAGES{RST_VAL}};
                else        r_chain <= {r_chain[STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_rx.sv
// ============================================================================
// spi_rx : SPI mode-0 slave receiver, MSB first, valid/ready output with
//          overrun and abort pulses. Define SPI_RX_SYNC_EN for async masters.
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_rx
    import spi_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             ss,
    input  logic             sdi,
    output logic [WIDTH-1:0] dat,
    output logic             vld,
    input  logic             rdy,
    output logic             ovr,
    output logic             abrt
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);
`ifdef SPI_RX_SYNC_EN
    // Two synchronizer flops followed by the input register.
    localparam int C_COND_STAGES = 3;
`else
    localparam int C_COND_STAGES = 1;
`endif
    localparam logic [1:0]         C_FILL_DONE = 2'(C_COND_STAGES);
    localparam logic [C_CNT_W-1:0] C_LAST      = C_CNT_W'(WIDTH - 1);

    logic w_sclk;
    logic w_ss;
    logic w_sdi;
    logic w_sclk_rise;
    logic w_cond_ok;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_sclk_prev;
    logic [1:0]         r_fill;

    sync2 #(.STAGES(C_COND_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .q(w_sclk)
    );
    sync2 #(.STAGES(C_COND_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(ss), .q(w_ss)
    );
    sync2 #(.STAGES(C_COND_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .d(sdi), .q(w_sdi)
    );

    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    // Until the conditioning pipe has refilled after reset, w_ss shows the
    // reset value rather than the pin, so WAIT must not trust it yet.
    assign w_cond_ok   = (r_fill == C_FILL_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_sclk_prev <= 1'b0;
            r_fill      <= 2'd0;
            dat         <= '0;
            vld         <= 1'b0;
            ovr         <= 1'b0;
            abrt        <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            ovr         <= 1'b0;
            abrt        <= 1'b0;
            if (!w_cond_ok) r_fill <= r_fill + 2'd1;
            if (vld && rdy) vld <= 1'b0;

            case (r_state)
                ST_WAIT: begin
                    if (w_cond_ok && w_ss) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!w_ss) begin
                        r_state <= ST_RECV;
                        r_cnt   <= '0;
                    end
                end
                ST_RECV: begin
                    if (w_ss) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        if (r_cnt != '0) abrt <= 1'b1;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[WIDTH-2:0], w_sdi};
                        if (r_cnt == C_LAST) begin
                            r_cnt <= '0;
                            dat   <= {r_shift[WIDTH-2:0], w_sdi};
                            vld   <= 1'b1;
                            ovr   <= vld & ~rdy;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_WAIT;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_rx.sv
// ============================================================================
// tb_spi_rx : self-checking bench for spi_rx (table vectors + scoreboard)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk;
    logic         ss;
    logic         sdi;
    logic         rdy;
    logic [W-1:0] dat;
    logic         vld;
    logic         ovr;
    logic         abrt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_ovr  = 0;
    int n_abrt = 0;
    int cyc_vld_rise  = 0;
    int last_rise_cyc = 0;
    logic vld_prev = 1'b0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        int           nbits;
        int           exp_abrt;
        logic [W-1:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_rx #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sclk (sclk),
        .ss   (ss),
        .sdi  (sdi),
        .dat  (dat),
        .vld  (vld),
        .rdy  (rdy),
        .ovr  (ovr),
        .abrt (abrt)
    );

    // Consumer side: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ovr)  n_ovr++;
            if (abrt) n_abrt++;
            if (vld && !vld_prev) cyc_vld_rise = cyc;
            if (vld && rdy) begin
                n_acc++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL accept: unexpected word dat=%h, none expected", dat);
                end else begin
                    automatic logic [W-1:0] e = exp_q.pop_front();
                    if (dat !== e) begin
                        errors++;
                        $display("FAIL accept: dat=%h expected %h", dat, e);
                    end
                end
            end
        end
        vld_prev = vld;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] data, input int nbits, input int half,
                             input bit push);
        for (int k = 0; k < nbits; k++) begin
            sdi  = data[W-1-k];
            sclk = 1'b0;
            tick(half);
            sclk = 1'b1;
            if (k == nbits - 1) begin
                last_rise_cyc = cyc;
                if (push) exp_q.push_back(data);
            end
            tick(half);
        end
        sclk = 1'b0;
        tick(half);
    endtask

    task automatic frame(input logic [W-1:0] data, input int nbits, input int half,
                         input bit push);
        ss = 1'b0;
        tick(2);
        send_bits(data, nbits, half, push);
        ss = 1'b1;
        tick(4);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, b0, o0;

        vecs[0] = '{8'hA5, 8, 0, 8'hA5};
        vecs[1] = '{8'h00, 8, 0, 8'h00};
        vecs[2] = '{8'hFF, 5, 1, 8'h00};
        vecs[3] = '{8'hFF, 8, 0, 8'hFF};
        vecs[4] = '{8'h01, 8, 0, 8'h01};
        vecs[5] = '{8'h80, 8, 0, 8'h80};
        vecs[6] = '{8'h00, 7, 1, 8'h80};

        rst_n = 1'b0;
        sclk  = 1'b0;
        ss    = 1'b1;
        sdi   = 1'b0;
        rdy   = 1'b1;
        tick(3);
        chk("reset_dat",  32'(dat),  32'h0);
        chk("reset_vld",  32'(vld),  32'h0);
        chk("reset_ovr",  32'(ovr),  32'h0);
        chk("reset_abrt", 32'(abrt), 32'h0);
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 7; i++) begin
            a0 = n_acc; b0 = n_abrt; o0 = n_ovr;
            frame(vecs[i].data, vecs[i].nbits, 2, vecs[i].nbits == W);
            chk($sformatf("vec%0d_abrt", i), 32'(n_abrt - b0), 32'(vecs[i].exp_abrt));
            chk($sformatf("vec%0d_ovr", i),  32'(n_ovr - o0),  32'h0);
            chk($sformatf("vec%0d_acc", i),  32'(n_acc - a0),  32'(vecs[i].nbits == W));
            chk($sformatf("vec%0d_dat", i),  32'(dat),         32'(vecs[i].exp_dat));
            chk($sformatf("vec%0d_vld", i),  32'(vld),         32'h0);
        end

        // Two words back to back with ss held low.
        a0 = n_acc; b0 = n_abrt;
        ss = 1'b0;
        tick(2);
        send_bits(8'h3C, 8, 2, 1'b1);
        send_bits(8'hC3, 8, 2, 1'b1);
        ss = 1'b1;
        tick(4);
        chk("b2b_acc",  32'(n_acc - a0),  32'd2);
        chk("b2b_dat",  32'(dat),         32'hC3);
        chk("b2b_abrt", 32'(n_abrt - b0), 32'h0);

        // Overrun: second word lands while the first is still unconsumed.
        a0 = n_acc; o0 = n_ovr;
        rdy = 1'b0;
        frame(8'h11, 8, 2, 1'b0);
        frame(8'h22, 8, 2, 1'b1);
        chk("ovr_count", 32'(n_ovr - o0), 32'd1);
        chk("ovr_dat",   32'(dat),        32'h22);
        chk("ovr_vld",   32'(vld),        32'h1);
        tick(5);
        chk("ovr_vld_hold", 32'(vld), 32'h1);
        rdy = 1'b1;
        tick(2);
        chk("ovr_vld_clr", 32'(vld),         32'h0);
        chk("ovr_acc",     32'(n_acc - a0),  32'd1);

        // Completion in the same cycle the old word is consumed: no overrun.
        a0 = n_acc; o0 = n_ovr;
        rdy = 1'b0;
        frame(8'h11, 8, 2, 1'b1);
        ss = 1'b0;
        tick(2);
        send_bits(8'h66, 7, 2, 1'b0);
        sdi  = 1'b0;
        sclk = 1'b0;
        tick(2);
        sclk = 1'b1;
        exp_q.push_back(8'h66);
        tick(1);
        rdy = 1'b1;
        tick(1);
        sclk = 1'b0;
        tick(2);
        ss = 1'b1;
        tick(4);
        chk("coinc_ovr", 32'(n_ovr - o0), 32'h0);
        chk("coinc_acc", 32'(n_acc - a0), 32'd2);
        chk("coinc_dat", 32'(dat),        32'h66);

        // Reset in the middle of a frame, ss stays low afterwards.
        a0 = n_acc; b0 = n_abrt;
        ss = 1'b0;
        tick(2);
        send_bits(8'hE0, 3, 2, 1'b0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        send_bits(8'hFF, 5, 2, 1'b0);
        ss = 1'b1;
        tick(4);
        chk("rst_mid_vld",  32'(vld),         32'h0);
        chk("rst_mid_dat",  32'(dat),         32'h0);
        chk("rst_mid_acc",  32'(n_acc - a0),  32'h0);
        chk("rst_mid_abrt", 32'(n_abrt - b0), 32'h0);
        frame(8'h81, 8, 2, 1'b1);
        chk("rst_next_dat", 32'(dat),        32'h81);
        chk("rst_next_acc", 32'(n_acc - a0), 32'd1);

        // clk/2 master: vld one clk after the 8th edge is detected.
        frame(8'h5A, 8, 1, 1'b1);
        chk("fast_dat",     32'(dat),          32'h5A);
        chk("fast_latency", 32'(cyc_vld_rise), 32'(last_rise_cyc + 2));

        tick(4);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_rx.md
SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 Parameter WIDTH, default 8, bits per frame (legal range 2..32).
REQ-002 Signal clk, input, 1, system clock; all flops on rising edge.
REQ-003 Signal rst_n, input, 1, asynchronous active-low reset.
REQ-004 Signal sclk, input, 1, serial clock from master, idle low.
REQ-005 Signal ss, input, 1, slave select, active low.
REQ-006 Signal sdi, input, 1, serial data in, MSB first.
REQ-007 Signal dat, output, WIDTH, last complete received word.
REQ-008 Signal vld, output, 1, dat holds an unconsumed word.
REQ-009 Signal rdy, input, 1, consumer accepts dat when vld and rdy are both high.
REQ-010 Signal ovr, output, 1, one-clk pulse: word completed while the previous word was still unconsumed.
REQ-011 Signal abrt, output, 1, one-clk pulse: ss deasserted with a partial word pending.

Function
REQ-012 Data SHALL be sampled on rising sclk edges, detected in clk domain as current=1 and previous=0 of the conditioned sclk.
REQ-013 Each sampled bit SHALL shift into shift-register LSB; first bit becomes dat MSB.
REQ-014 FSM states SHALL be: WAIT (ss must go high), IDLE (ss high, no frame), RECV (ss low, receiving).
REQ-015 Transitions SHALL be: WAIT->IDLE when ss=1; IDLE->RECV when ss=0, clearing bit count; RECV->IDLE when ss=1.
REQ-016 Bit count SHALL be ceil(log2(WIDTH+1)) bits; at WIDTH bits it SHALL wrap to 0, staying in RECV for back-to-back words.
REQ-017 On the WIDTH-th bit, dat SHALL load the full word and vld SHALL assert on the next clk edge.
REQ-018 vld SHALL stay high until a clk edge with rdy=1; dat SHALL be stable while vld=1 unless overwritten per REQ-019.
REQ-019 A word completing while vld=1 and rdy=0 SHALL overwrite dat, keep vld=1, and pulse ovr.
REQ-020 If completion coincides with vld=1 and rdy=1, the new word SHALL load, vld SHALL stay 1, and ovr SHALL NOT pulse.
REQ-021 When ss rises in RECV with bit count 1..WIDTH-1: partial word discarded, abrt pulses, vld/dat unaffected.
REQ-022 A rising sclk edge in the same cycle as ss high SHALL be ignored; ss has priority.
REQ-023 Latency from detected WIDTH-th edge to vld=1 SHALL be 1 clk.
REQ-024 sclk edges while not in RECV SHALL be ignored.
REQ-025 Minimum sclk high and low time SHALL be 1 clk each (supports clk/2 sclk).

Reset
REQ-026 On rst_n=0: FSM=WAIT, shift register=0, count=0, dat=0, vld=0, ovr=0, abrt=0, conditioning flops=idle values (sclk 0, ss 1, sdi 0).
REQ-027 Reset mid-frame SHALL discard the frame; no vld until a full frame follows ss high.

Configuration
REQ-028 With SPI_RX_SYNC_EN defined, sclk/ss/sdi SHALL each pass through a 2-flop synchronizer; pin-to-edge-detect lag is 3 clk.
REQ-029 Without SPI_RX_SYNC_EN, inputs SHALL be registered once; lag is 1 clk; for same-clk-domain masters only.

Structure
REQ-030 Package spi_pkg SHALL hold the FSM state encoding and the default WIDTH constant.
REQ-031 Sub-module sync2 (2-flop synchronizer with async active-low reset and reset-value parameter) SHALL be instantiated three times under SPI_RX_SYNC_EN.

Verification
REQ-032 Frame 0xA5, rdy=1 -> one vld pulse, dat=0xA5, ovr=0, abrt=0.
REQ-033 ss held low, words 0x3C then 0xC3 back-to-back, rdy=1 -> two vld acceptances, dat 0x3C then 0xC3.
REQ-034 ss raised after 5 bits of 0xFF -> abrt one-clk pulse, no vld, dat unchanged.
REQ-035 rdy=0, frames 0x11 then 0x22 -> ovr pulses once, dat=0x22, vld stays 1 until rdy=1.
REQ-036 rst_n pulsed with ss low after 3 bits, ss stays low 5 more bits -> no vld; next full frame 0x81 after ss high -> dat=0x81.
REQ-037 Loopback with same-clk clk/2 SPI master, macro undefined, byte 0x5A -> dat=0x5A, vld 1 clk after 8th edge detect.
